rvc_fetch_aligner: RTL
======================

# rvc_fetch_aligner

Instruction-fetch front end for the RV32IC core. It reads 32-bit aligned words from the instruction memory and splits them into a stream of 16-bit (compressed) and 32-bit instructions at halfword granularity, including 32-bit instructions that span two memory words. It sits between the instruction memory and the decode/expand stage. It consumes the contents that the benches preload into instruction memory.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset; bit 0 must be 0.
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- redirect_i  input  1  branch/jump redirect strobe, one cycle.
- redirect_pc_i  input  32  redirect target; bit 0 is ignored and treated as 0.
- imem_req_o  output  1  read request for imem_addr_o.
- imem_addr_o  output  32  word address; bits [1:0] are always 0.
- imem_rvalid_i  input  1  read data valid, exactly one cycle after the request.
- imem_rdata_i  input  32  read data, little-endian.
- instr_valid_o  output  1  a complete instruction is presented.
- instr_ready_i  input  1  decode accepts the presented instruction.
- instr_o  output  32  instruction; compressed instructions are zero-extended as {16'h0, hw}.
- instr_pc_o  output  32  PC of instr_o; halfword aligned.
- instr_is_c_o  output  1  instr_o is compressed, i.e. bits [1:0] != 2'b11.

## Operation
- State:
  - word buffer (word_q, word_vld, word_addr, off ∈ {0,2});
  - spill halfword (spill_q, spill_vld, spill_pc);
  - pend: one request outstanding;
  - drop: discard the next response;
  - started: cleared in reset.
- Request rule: imem_req_o = started && !pend && (!word_vld || word consumed this cycle). At most one request outstanding. fetch_addr advances by 4 per request.
- A response loads the word buffer and clears pend, unless drop is set. If drop is set, the response is discarded and drop clears.
- Presentation, which is combinational from registers:
  - spill_vld && word_vld: present {word_q[15:0], spill_q}, PC = spill_pc, 32-bit. On accept, clear spill and set off=2.
  - word_vld, off=0, word_q[1:0]!=11: present compressed word_q[15:0]. On accept, set off=2.
  - word_vld, off=0, word_q[1:0]==11: present word_q, 32-bit. On accept, the word is consumed.
  - word_vld, off=2, word_q[17:16]!=11: present compressed word_q[31:16]. On accept, the word is consumed.
  - word_vld, off=2, word_q[17:16]==11: instr_valid_o=0. Move the upper half to the spill with spill_pc=word_addr+2, and consume the word without a handshake.
- Handshake: a transfer occurs on instr_valid_o && instr_ready_i. While stalled, instr_o, instr_pc_o and instr_is_c_o are held stable, and no new request is issued while word_vld is set.
- Redirect has priority over everything:
  - clear word_vld and spill_vld;
  - set drop = pend || imem_rvalid_i-pending;
  - fetch_addr = {pc[31:2],2'b00}; the first word loads with off = pc[1].
  - A handshake in the same cycle is treated as consumed and has no side effect.

## Timing
- Reset values: instr_valid_o=0, instr_o=0, instr_pc_o=0, instr_is_c_o=0, imem_req_o=0, imem_addr_o=RESET_PC.
- The first request is made in the first cycle after rst_n is released. The first instr_valid_o comes 2 cycles later.
- Request at cycle N, response at N+1, instr_valid_o at N+2.
- Sustained throughput with ready held high:
  - 32-bit aligned code: 1 instruction per 2 cycles;
  - compressed-only code: 2 instructions per 3 cycles;
  - a spanning instruction costs one extra bubble cycle.
- After a redirect at cycle R: the new request is at R+1, and the first instruction is valid at R+3, including when a stale response arrives at R+1.
- Asserting rst_n mid-operation (spill held, request pending) clears all state immediately. A late rvalid is ignored because pend=0 and started=0.

## Structure
- Package rvc_fetch_pkg contains:
  - RVC_HW_W=16 and ILEN=32;
  - function is_compressed(logic [1:0]);
  - the typedef of the presentation source enum {SRC_NONE, SRC_SPILL, SRC_LO, SRC_HI}.
- A single module with no sub-modules. The presentation mux is an always_comb block over the SRC_* select.

## Test plan
- Memory at 0x0 holds 0x00A00093 and at 0x4 holds 0x00108113 → instructions at pc 0x0 and 0x4, instr_is_c_o=0, 2 cycles apart.
- Memory at 0x0 holds 0x8D6D8D6D → two compressed transfers, pc 0x0 and 0x2, instr_o=0x00008D6D each.
- Memory at 0x0 holds 0x00938D6D and at 0x4 holds 0x450100A0 → pc 0x0 C 0x8D6D, then pc 0x2 32-bit 0x00A00093, then pc 0x6 C 0x4501.
- Redirect to 0x6 in the cycle after a request to 0x8 → the 0x8 response is dropped, the next request is 0x4, and the first instruction is at pc 0x6 from word[31:16].
- Hold instr_ready_i=0 for 5 cycles with a valid instruction → outputs are stable, imem_req_o stays 0, and the transfer completes on the 6th cycle.
- Assert rst_n low while the spill is valid and a request is pending → all outputs match their reset values, and after release the first request goes to RESET_PC.

Source files
------------

// File: rtl/rvc_fetch_pkg.sv
// rtl/rvc_fetch_pkg.sv - widths, compressed-opcode test and presentation select for the RVC fetch aligner
package rvc_fetch_pkg;

  localparam int RVC_HW_W = 16;
  localparam int ILEN     = 32;

  typedef enum logic [1:0] {SRC_NONE, SRC_SPILL, SRC_LO, SRC_HI} src_e;

  function automatic logic is_compressed(input logic [1:0] op);
    return op != 2'b11;
  endfunction

endpackage

// File: rtl/rvc_fetch_aligner.sv
// rtl/rvc_fetch_aligner.sv - splits aligned 32-bit imem words into a 16/32-bit instruction stream
module rvc_fetch_aligner
  import rvc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [31:0]     redirect_pc_i,
  output logic            imem_req_o,
  output logic [31:0]     imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [ILEN-1:0] instr_o,
  output logic [31:0]     instr_pc_o,
  output logic            instr_is_c_o
);

  logic [ILEN-1:0]     word_q;
  logic [31:0]         word_addr;
  logic                word_vld;
  logic                off_q;
  logic                load_off;
  logic [RVC_HW_W-1:0] spill_q;
  logic [31:0]         spill_pc;
  logic                spill_vld;
  logic [31:0]         fetch_addr;
  logic                pend;
  logic                drop;
  logic                started;

  src_e src;
  logic lo_c;
  logic hi_c;
  logic xfer;
  logic spill_move;
  logic word_done;
  logic rsp_load;
  logic unused_redirect_bit0;

  assign unused_redirect_bit0 = redirect_pc_i[0];

  assign lo_c = is_compressed(word_q[1:0]);
  assign hi_c = is_compressed(word_q[17:16]);

  always_comb begin
    src = SRC_NONE;
    if (word_vld) begin
      if (spill_vld)   src = SRC_SPILL;
      else if (!off_q) src = SRC_LO;
      else if (hi_c)   src = SRC_HI;
    end
  end

  // Upper half starts a 32-bit instruction: park it and fetch the next word.
  assign spill_move    = word_vld && !spill_vld && off_q && !hi_c;
  assign instr_valid_o = (src != SRC_NONE);
  assign xfer          = instr_valid_o && instr_ready_i;
  assign word_done     = spill_move || (xfer && ((src == SRC_HI) || ((src == SRC_LO) && !lo_c)));
  assign imem_req_o    = started && !pend && (!word_vld || word_done);
  assign imem_addr_o   = fetch_addr;
  assign rsp_load      = imem_rvalid_i && pend && !drop;

  always_comb begin
    instr_o      = '0;
    instr_pc_o   = '0;
    instr_is_c_o = 1'b0;
    case (src)
      SRC_SPILL: begin
        instr_o    = {word_q[15:0], spill_q};
        instr_pc_o = spill_pc;
      end
      SRC_LO: begin
        instr_o      = lo_c ? {16'h0, word_q[15:0]} : word_q;
        instr_pc_o   = word_addr;
        instr_is_c_o = lo_c;
      end
      SRC_HI: begin
        instr_o      = {16'h0, word_q[31:16]};
        instr_pc_o   = word_addr + 32'd2;
        instr_is_c_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      word_addr  <= '0;
      word_vld   <= 1'b0;
      off_q      <= 1'b0;
      load_off   <= RESET_PC[1];
      spill_q    <= '0;
      spill_pc   <= '0;
      spill_vld  <= 1'b0;
      fetch_addr <= {RESET_PC[31:2], 2'b00};
      pend       <= 1'b0;
      drop       <= 1'b0;
      started    <= 1'b0;
    end else begin
      started <= 1'b1;
      if (redirect_i) begin
        // A request leaving this cycle returns stale data next cycle.
        word_vld   <= 1'b0;
        spill_vld  <= 1'b0;
        pend       <= 1'b0;
        drop       <= imem_req_o || (pend && !imem_rvalid_i);
        fetch_addr <= {redirect_pc_i[31:2], 2'b00};
        load_off   <= redirect_pc_i[1];
      end else begin
        if (imem_req_o) begin
          fetch_addr <= fetch_addr + 32'd4;
          pend       <= 1'b1;
        end
        if (xfer) begin
          case (src)
            SRC_SPILL: begin
              spill_vld <= 1'b0;
              off_q     <= 1'b1;
            end
            SRC_LO: begin
              if (lo_c) off_q <= 1'b1;
              else      word_vld <= 1'b0;
            end
            SRC_HI:  word_vld <= 1'b0;
            default: ;
          endcase
        end
        if (spill_move) begin
          spill_q   <= word_q[31:16];
          spill_pc  <= word_addr + 32'd2;
          spill_vld <= 1'b1;
          word_vld  <= 1'b0;
        end
        if (imem_rvalid_i && drop) drop <= 1'b0;
        if (rsp_load) begin
          word_q    <= imem_rdata_i;
          word_addr <= fetch_addr - 32'd4;
          word_vld  <= 1'b1;
          off_q     <= load_off;
          load_off  <= 1'b0;
          pend      <= 1'b0;
        end
      end
    end
  end

endmodule
